// File: rtl/div_top.sv
// Sequential radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Shares the shift-add multiplier's START/STALL/DONE handshake.
module div_top #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SIGN,
  input  logic              START,
  input  logic [DATA_W-1:0] DIVIDEND,
  input  logic [DATA_W-1:0] DIVISOR,
  input  logic              STALL_DIV,
  output logic [DATA_W-1:0] QUOTIENT,
  output logic [DATA_W-1:0] REMAINDER,
  output logic              DONE
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] dvsr_q, dvsr_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;
  logic [DATA_W-1:0] quotient_q, quotient_d;
  logic [DATA_W-1:0] remainder_q, remainder_d;
  logic              done_q, done_d;

  logic              dvd_neg, dvs_neg, div_zero, div_ovf;
  logic signed [DATA_W:0] trial;

  function automatic logic [DATA_W-1:0] cond_neg(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvsr_d      = dvsr_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = done_q;

    dvd_neg  = SIGN & DIVIDEND[DATA_W-1];
    dvs_neg  = SIGN & DIVISOR[DATA_W-1];
    div_zero = (DIVISOR == '0);
    div_ovf  = SIGN && (DIVIDEND == {1'b1, {(DATA_W-1){1'b0}}}) && (DIVISOR == '1);
    // Shifted partial remainder needs DATA_W+1 bits before the compare.
    trial    = $signed({rem_q, quo_q[DATA_W-1]}) - $signed({1'b0, dvsr_q});

    if (!STALL_DIV) begin
      if (START) begin
        done_d = 1'b0;
        cnt_d  = CNT_W'(DATA_W);
        // Special cases preload the final answer and skip straight to FIX unsigned.
        if (div_zero) begin
          quo_d   = '1;
          rem_d   = DIVIDEND;
          q_neg_d = 1'b0;
          r_neg_d = 1'b0;
          state_d = S_FIX;
        end else if (div_ovf) begin
          quo_d   = DIVIDEND;
          rem_d   = '0;
          q_neg_d = 1'b0;
          r_neg_d = 1'b0;
          state_d = S_FIX;
        end else begin
          quo_d   = cond_neg(dvd_neg, DIVIDEND);
          rem_d   = '0;
          dvsr_d  = cond_neg(dvs_neg, DIVISOR);
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          state_d = S_RUN;
        end
      end else begin
        case (state_q)
          S_RUN: begin
            quo_d = {quo_q[DATA_W-2:0], ~trial[DATA_W]};
            rem_d = (trial < 0) ? {rem_q[DATA_W-2:0], quo_q[DATA_W-1]} : trial[DATA_W-1:0];
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_FIX;
          end
          S_FIX: begin
            quotient_d  = cond_neg(q_neg_q, quo_q);
            remainder_d = cond_neg(r_neg_q, rem_q);
            done_d      = 1'b1;
            state_d     = S_IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvsr_q      <= dvsr_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
    end
  end

  assign QUOTIENT  = quotient_q;
  assign REMAINDER = remainder_q;
  assign DONE      = done_q;

endmodule
